// File: rtl/fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO family.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_pkg;

   // Read-mode selector; the FIFO's FWFT parameter is compared against this.
   typedef enum int {
      FIFO_STD  = 0,
      FIFO_FWFT = 1
   } fifo_mode_e;

   // True when v is a positive power of two.
   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array for the FIFO, no reset on contents.
// Latency: write lands at the clock edge; read is combinational from raddr.
// Backpressure: none; the caller decides when we is allowed.
//
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (asynchronous)
module fifo_ram #(
   parameter int DEPTH      = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_WIDTH-1:0]    wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_WIDTH-1:0]    rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO with selectable FWFT read, thresholds, level and sticky errors.
// Latency: FWFT=0 o_data registered 1 cycle after accepted rden; FWFT=1 head shown combinationally.
// Backpressure: writes to a full FIFO are rejected unless a read is accepted in the
//   same cycle; reads of an empty FIFO are always rejected; rejections set sticky flags.
//
// Ports:
//   clk, rst_n      - clock (rising edge), asynchronous active-low reset
//   flush           - synchronous clear, overrides wren/rden
//   wren, i_data    - write request and data
//   rden, o_data    - read request (pop) and read data
//   full, empty     - level == DEPTH / level == 0
//   almost_full     - level >= AF_THRESH
//   almost_empty    - level <= AE_THRESH
//   level           - occupancy 0..DEPTH
//   overflow        - sticky: a write was rejected
//   underflow       - sticky: a read was rejected
module sync_fifo_v2
   import fifo_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int DATA_WIDTH = 8,
   parameter int FWFT       = 0,
   parameter int AF_THRESH  = DEPTH - 2,
   parameter int AE_THRESH  = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       wren,
   input  logic [DATA_WIDTH-1:0]      i_data,
   input  logic                       rden,
   output logic [DATA_WIDTH-1:0]      o_data,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int PTR_W = $clog2(DEPTH);

   localparam logic [PTR_W:0] DEPTH_L = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0] AF_L    = (PTR_W + 1)'(AF_THRESH);
   localparam logic [PTR_W:0] AE_L    = (PTR_W + 1)'(AE_THRESH);

   // Elaboration-time parameter sanity checks.
   if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_chk_depth
      $error("sync_fifo_v2: DEPTH must be a power of two and at least 2");
   end
   if (AF_THRESH > DEPTH) begin : g_chk_af
      $error("sync_fifo_v2: AF_THRESH must not exceed DEPTH");
   end
   if (AE_THRESH >= DEPTH) begin : g_chk_ae
      $error("sync_fifo_v2: AE_THRESH must be less than DEPTH");
   end

   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic                  rd_acc;
   logic                  wr_acc;

   // Flags decode straight from the registered level.
   assign full         = (level == DEPTH_L);
   assign empty        = (level == '0);
   assign almost_full  = (level >= AF_L);
   assign almost_empty = (level <= AE_L);

   // A full FIFO can still take a write when the head leaves in the same cycle.
   // An empty FIFO never bypasses: the written word is readable next cycle.
   assign rd_acc = rden && !empty;
   assign wr_acc = wren && (!full || rd_acc);

   fifo_ram #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (wr_acc && !flush),
      .waddr (wr_ptr),
      .wdata (i_data),
      .raddr (rd_ptr),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_acc, rd_acc})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (wren && !wr_acc) begin
            overflow <= 1'b1;
         end
         if (rden && !rd_acc) begin
            underflow <= 1'b1;
         end
      end
   end

   if (FWFT == int'(FIFO_FWFT)) begin : g_fwft
      // Head entry shown directly; meaningless while empty.
      assign o_data = ram_rdata;
   end else begin : g_std
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            o_data <= '0;
         end else if (flush) begin
            o_data <= '0;
         end else if (rd_acc) begin
            o_data <= ram_rdata;
         end
      end
   end

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Directed self-checking bench for sync_fifo_v2 in registered and FWFT read modes.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_sync_fifo_v2;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   // Registered-read instance
   logic       s_flush, s_wren, s_rden;
   logic [7:0] s_din, s_dout;
   logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
   logic [3:0] s_level;

   // Show-ahead instance
   logic       f_flush, f_wren, f_rden;
   logic [7:0] f_din, f_dout;
   logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
   logic [3:0] f_level;

   int n_chk  = 0;
   int n_pass = 0;

   sync_fifo_v2 #(.DEPTH(8), .DATA_WIDTH(8), .FWFT(0)) u_std (
      .clk(clk), .rst_n(rst_n), .flush(s_flush), .wren(s_wren), .i_data(s_din),
      .rden(s_rden), .o_data(s_dout), .full(s_full), .empty(s_empty),
      .almost_full(s_af), .almost_empty(s_ae), .level(s_level),
      .overflow(s_ovf), .underflow(s_udf)
   );

   sync_fifo_v2 #(.DEPTH(8), .DATA_WIDTH(8), .FWFT(1)) u_fwft (
      .clk(clk), .rst_n(rst_n), .flush(f_flush), .wren(f_wren), .i_data(f_din),
      .rden(f_rden), .o_data(f_dout), .full(f_full), .empty(f_empty),
      .almost_full(f_af), .almost_empty(f_ae), .level(f_level),
      .overflow(f_ovf), .underflow(f_udf)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic std_write(input logic [7:0] d);
      s_wren = 1'b1;
      s_din  = d;
      tick();
      s_wren = 1'b0;
   endtask

   logic [7:0] q[$];
   logic [7:0] exp_d;
   logic [7:0] din;

   initial begin
      rst_n   = 1'b0;
      s_flush = 1'b0; s_wren = 1'b0; s_rden = 1'b0; s_din = 8'h00;
      f_flush = 1'b0; f_wren = 1'b0; f_rden = 1'b0; f_din = 8'h00;
      #12;

      // Reset state
      chk("rst_level", s_level, 0);
      chk("rst_empty", s_empty, 1);
      chk("rst_full",  s_full, 0);
      chk("rst_ae",    s_ae, 1);
      chk("rst_af",    s_af, 0);
      chk("rst_dout",  s_dout, 8'h00);
      chk("rst_ovf",   s_ovf, 0);
      chk("rst_udf",   s_udf, 0);
      rst_n = 1'b1;
      tick();

      // Fill 0x11..0x88
      for (int i = 0; i < 8; i++) begin
         std_write(8'((i + 1) * 8'h11));
         chk("fill_level", s_level, i + 1);
         chk("fill_af", s_af, (i + 1 >= 6) ? 1 : 0);
      end
      chk("fill_full", s_full, 1);
      std_write(8'hEE);
      chk("ovf_set", s_ovf, 1);
      chk("ovf_level", s_level, 8);

      // Drain
      for (int i = 0; i < 8; i++) begin
         s_rden = 1'b1;
         tick();
         chk("drain_dout", s_dout, (i + 1) * 8'h11);
         chk("drain_level", s_level, 7 - i);
         chk("drain_ae", s_ae, (7 - i <= 1) ? 1 : 0);
      end
      s_rden = 1'b0;
      chk("drain_empty", s_empty, 1);
      s_rden = 1'b1;
      tick();
      s_rden = 1'b0;
      chk("udf_set", s_udf, 1);
      chk("udf_dout_hold", s_dout, 8'h88);
      chk("udf_level", s_level, 0);

      // Flush clears sticky flags and o_data
      s_flush = 1'b1;
      tick();
      s_flush = 1'b0;
      chk("flush_ovf", s_ovf, 0);
      chk("flush_udf", s_udf, 0);
      chk("flush_dout", s_dout, 0);

      // Full FIFO, simultaneous read+write across pointer wrap
      q.delete();
      for (int i = 0; i < 8; i++) begin
         std_write(8'((i + 1) * 8'h11));
         q.push_back(8'((i + 1) * 8'h11));
      end
      for (int k = 0; k < 20; k++) begin
         din    = 8'(8'h99 + k);
         s_wren = 1'b1;
         s_rden = 1'b1;
         s_din  = din;
         tick();
         exp_d = q.pop_front();
         q.push_back(din);
         chk("rw_dout", s_dout, exp_d);
         chk("rw_level", s_level, 8);
      end
      s_wren = 1'b0;
      s_rden = 1'b0;
      chk("rw_no_ovf", s_ovf, 0);
      for (int i = 0; i < 8; i++) begin
         s_rden = 1'b1;
         tick();
         exp_d = q.pop_front();
         chk("wrap_dout", s_dout, exp_d);
         chk("wrap_level", s_level, 7 - i);
      end
      s_rden = 1'b0;

      // Empty FIFO, simultaneous read+write: read rejected
      s_wren = 1'b1; s_rden = 1'b1; s_din = 8'hA5;
      tick();
      s_wren = 1'b0;
      chk("ew_udf", s_udf, 1);
      chk("ew_level", s_level, 1);
      chk("ew_dout_hold", s_dout, exp_d);
      tick();
      s_rden = 1'b0;
      chk("ew_dout", s_dout, 8'hA5);
      chk("ew_level0", s_level, 0);
      chk("ew_empty", s_empty, 1);

      // Level 5 with overflow set, flush with same-cycle write
      for (int i = 0; i < 9; i++) begin
         std_write(8'(8'h40 + i));
      end
      chk("pre_ovf", s_ovf, 1);
      s_rden = 1'b1;
      tick(); tick(); tick();
      s_rden = 1'b0;
      chk("pre_level5", s_level, 5);
      s_flush = 1'b1; s_wren = 1'b1; s_din = 8'h5A;
      tick();
      s_flush = 1'b0; s_wren = 1'b0;
      chk("fl_level", s_level, 0);
      chk("fl_empty", s_empty, 1);
      chk("fl_ovf", s_ovf, 0);
      chk("fl_udf", s_udf, 0);
      tick();
      chk("fl_wr_ignored", s_level, 0);

      // FWFT instance
      f_wren = 1'b1; f_din = 8'h3C;
      tick();
      f_wren = 1'b0;
      chk("fw_dout", f_dout, 8'h3C);
      chk("fw_empty", f_empty, 0);
      chk("fw_level", f_level, 1);
      tick();
      chk("fw_dout_hold", f_dout, 8'h3C);
      f_rden = 1'b1;
      tick();
      f_rden = 1'b0;
      chk("fw_pop_empty", f_empty, 1);
      chk("fw_pop_level", f_level, 0);
      f_wren = 1'b1; f_din = 8'h4D;
      tick();
      f_din = 8'h5E;
      tick();
      f_wren = 1'b0;
      chk("fw_head", f_dout, 8'h4D);
      f_rden = 1'b1;
      tick();
      f_rden = 1'b0;
      chk("fw_next", f_dout, 8'h5E);
      chk("fw_next_level", f_level, 1);

      // Asynchronous reset mid-stream
      std_write(8'h01);
      std_write(8'h02);
      s_rden = 1'b1;
      tick();
      s_rden = 1'b0;
      s_wren = 1'b1; s_din = 8'h03;
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_level", s_level, 0);
      chk("ar_empty", s_empty, 1);
      chk("ar_dout", s_dout, 0);
      chk("ar_ovf", s_ovf, 0);
      chk("ar_udf", s_udf, 0);
      chk("ar_ae", s_ae, 1);
      chk("ar_f_level", f_level, 0);
      s_wren = 1'b0;
      #10;
      rst_n = 1'b1;
      tick();
      chk("ar_after_level", s_level, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sync_fifo_v2.md
Name: sync_fifo_v2

Overview:
- Parametrised single-clock FIFO; next generation of the team's minilab FIFO that buffers operand streams between the memory fill logic and the MAC array.
- Adds:
  - selectable first-word-fall-through (FWFT) read mode
  - programmable almost-full and almost-empty thresholds
  - an occupancy level output
  - a synchronous flush
  - sticky overflow and underflow error flags
- Count is correct under simultaneous read and write.

Parameters:
- DEPTH, 8, number of entries; must be a power of two and at least 2.
- DATA_WIDTH, 8, width of data in and data out.
- FWFT, 0, read mode. 0 = registered read: o_data updates the cycle after an accepted rden. 1 = show-ahead: o_data presents the head entry whenever the FIFO is not empty.
- AF_THRESH, DEPTH-2, almost_full asserts when level >= AF_THRESH.
- AE_THRESH, 1, almost_empty asserts when level <= AE_THRESH.
- Localparam PTR_W = $clog2(DEPTH).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear; highest priority.
- wren  in  1  write request.
- i_data  in  DATA_WIDTH  write data.
- rden  in  1  read request (pop).
- o_data  out  DATA_WIDTH  read data.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level >= AF_THRESH.
- almost_empty  out  1  level <= AE_THRESH.
- level  out  PTR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (async, rst_n low):
  - rd_ptr, wr_ptr and level are 0.
  - o_data is 0. Overflow and underflow are 0.
  - Hence empty = 1, full = 0, almost_empty = 1, and almost_full = (AF_THRESH == 0).
  - Storage array is not reset.
- Acceptance:
  - rd_acc = rden && !empty.
  - wr_acc = wren && (!full || rd_acc). A write to a full FIFO is accepted only when a read is accepted in the same cycle.
  - A read of an empty FIFO is never accepted, even with a same-cycle write. The written data becomes readable one cycle later.
- Level update:
  - wr_acc only: +1.
  - rd_acc only: -1.
  - Both accepted: level unchanged, both pointers advance.
  - Neither: hold.
- Pointers: PTR_W bits, advance by 1 on acceptance, wrap from DEPTH-1 to 0 naturally.
- Write: mem[wr_ptr] <= i_data on wr_acc.
- Read, FWFT=0:
  - On rd_acc, o_data <= mem[rd_ptr] (1-cycle latency).
  - Otherwise o_data holds its value.
- Read, FWFT=1:
  - o_data = mem[rd_ptr] combinationally; valid only while !empty.
  - The value while empty is don't-care; the bench must not check it.
  - rd_acc advances to the next entry, visible the following cycle.
- Flags full, empty, almost_full, almost_empty are combinational decodes of the registered level. There is no extra latency beyond the level update.
- Errors:
  - overflow <= 1 when wren && !wr_acc.
  - underflow <= 1 when rden && !rd_acc.
  - Both are sticky until flush or reset.
  - Rejected operations change no other state.
- Flush:
  - When flush is high at a clock edge: pointers, level, overflow and underflow go to 0. o_data goes to 0 when FWFT=0.
  - Same-cycle wren/rden are ignored and raise no error flags.
- Elaboration check: $error if DEPTH is not a power of two, or if AF_THRESH > DEPTH, or if AE_THRESH >= DEPTH.

Decomposition:
- Package fifo_pkg holds:
  - function is_pow2(int) for the elaboration checks
  - typedef enum fifo_mode_e {FIFO_STD=0, FIFO_FWFT=1}, which the FWFT parameter is compared against
- Sub-module fifo_ram: simple dual-port array with parameters DEPTH and DATA_WIDTH.
  - Synchronous write port.
  - Asynchronous read port addressed by rd_ptr.
  - No reset.
- sync_fifo_v2 holds the pointers, level, flags and the o_data register (FWFT=0).

Test Plan:
- Reset, then 8 writes of 0x11..0x88 (DEPTH=8, FWFT=0) -> full=1, level=8, almost_full asserted from level 6. A 9th write -> overflow=1, level stays 8.
- 8 reads after the fill -> o_data sequence 0x11..0x88, each 1 cycle after rden. empty=1. A 9th read -> underflow=1, o_data holds 0x88.
- Full FIFO, same-cycle wren (0x99) + rden -> level stays 8, no overflow, o_data=0x11. Head becomes 0x22 and 0x99 is at the tail. Repeat across 20 cycles so the pointers wrap -> order is preserved.
- Empty FIFO, same-cycle wren (0xA5) + rden -> read rejected, underflow=1, level=1. Next cycle rden -> o_data=0xA5, level=0.
- FWFT=1: write 0x3C -> the next cycle o_data=0x3C with empty=0, with no rden. Pulse rden -> empty=1, level=0.
- Level 5 with overflow set, assert flush together with wren -> level=0, empty=1, overflow=0, write ignored. Assert rst_n low mid-stream -> all outputs immediately at their reset values.
